// File: rtl/hack_mem_pkg.sv
// Shared definitions for the ram_array block: default geometry and clear-sequencer states.
package hack_mem_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 7;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, writing zero, while holding busy high.
module ram_clear_seq
    import hack_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter wraps back to 0 on the final clear edge, ready for the next reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q == CLEAR);
        clr_we   = (state_q == CLEAR);
        clr_addr = cnt_q;
    end

endmodule

// File: rtl/ram_array.sv
// Single-port word RAM with 1-cycle registered reads; write beats read on the same edge.
// Optional post-reset zero fill is enabled by defining RAM_ARRAY_CLEAR_EN.
module ram_array
    import hack_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ram_load,
    input  logic                  ram_read,
    input  logic [ADDR_WIDTH-1:0] ram_address,
    input  logic [DATA_WIDTH-1:0] ram_input,
    output logic [DATA_WIDTH-1:0] ram_output,
    output logic                  ram_valid,
    output logic                  ram_busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_vld_q, rd_vld_d;

    logic                  user_we;
    logic                  user_re;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

`ifdef RAM_ARRAY_CLEAR_EN
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    ram_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clock    (clock),
        .reset    (reset),
        .busy     (ram_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // The sequencer owns the write port for the whole clear; user requests are dropped meanwhile.
    always_comb begin
        mem_we    = clr_we | user_we;
        mem_addr  = clr_we ? clr_addr : ram_address;
        mem_wdata = clr_we ? '0 : ram_input;
    end
`else
    assign ram_busy = 1'b0;

    always_comb begin
        mem_we    = user_we;
        mem_addr  = ram_address;
        mem_wdata = ram_input;
    end
`endif

    always_comb begin
        user_we = ram_load & ~ram_busy;
        user_re = ram_read & ~ram_load & ~ram_busy;
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    always_comb begin
        rd_vld_d  = user_re;
        rd_data_d = user_re ? mem_q[ram_address] : rd_data_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

    assign ram_output = rd_data_q;
    assign ram_valid  = rd_vld_q;

endmodule

// File: doc/ram_array.md
RAM_ARRAY -- requirements
Module: ram_array

Interface
REQ-001 Parameter DATA_WIDTH, default 16, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 7, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ram_load  input  1  write request for the current cycle.
REQ-006 ram_read  input  1  read request for the current cycle.
REQ-007 ram_address  input  ADDR_WIDTH  word address for read or write.
REQ-008 ram_input  input  DATA_WIDTH  write data.
REQ-009 ram_output  output  DATA_WIDTH  registered read data.
REQ-010 ram_valid  output  1  one-cycle strobe: ram_output holds data from the read accepted on the previous edge.
REQ-011 ram_busy  output  1  high while the array is not accepting requests.

Function
REQ-012 Write accepted on the rising edge when ram_load=1 and ram_busy=0: mem[ram_address] <= ram_input.
REQ-013 Read accepted on the rising edge when ram_read=1, ram_load=0, ram_busy=0: ram_output <= mem[ram_address], ram_valid <= 1 on that same edge; read latency is exactly 1 cycle.
REQ-014 ram_load=1 with ram_read=1: write wins, no read, ram_valid <= 0, ram_output unchanged.
REQ-015 Read of an address written on an earlier edge returns the new value; no same-edge read/write conflict exists (REQ-014).
REQ-016 No accepted read on an edge: ram_valid <= 0, ram_output holds its last value.
REQ-017 Requests while ram_busy=1 are ignored and not queued; memory, ram_output, and ram_valid=0 are unaffected.
REQ-018 ram_address covers the full range 0..DEPTH-1; no out-of-range case exists.
REQ-019 Clear-sequencer FSM states: IDLE, CLEAR; ram_busy=1 exactly while in CLEAR.
REQ-020 CLEAR: each edge writes 0 to mem[clr_cnt], clr_cnt increments; at clr_cnt=DEPTH-1 writes 0 and goes to IDLE; the sequence takes exactly DEPTH cycles.
REQ-021 IDLE: stays IDLE; only reset re-enters CLEAR.

Reset
REQ-022 reset=1 asynchronously forces ram_output=0, ram_valid=0, clr_cnt=0, and state CLEAR (macro defined) or IDLE (macro undefined).
REQ-023 reset asserted mid-CLEAR restarts clearing from address 0 after release.
REQ-024 reset does not directly alter memory contents; only the clear sequence does.

Configuration
REQ-025 Macro RAM_ARRAY_CLEAR_EN defined: clear FSM compiled in; after reset ram_busy=1 for DEPTH cycles and all words then read 0.
REQ-026 Macro undefined: no FSM or counter logic; ram_busy is constant 0; contents after reset are unspecified (X in simulation).

Structure
REQ-027 Shared package hack_mem_pkg holds the DATA_WIDTH/ADDR_WIDTH defaults and the clear-state enum (IDLE, CLEAR).
REQ-028 Clear FSM and counter live in sub-module ram_clear_seq (outputs busy, clr_we, clr_addr); ram_array muxes its write port between it and the user.

Verification
REQ-029 Macro on, reset pulse, DEPTH=128 -> ram_busy high exactly 128 cycles; reading 0, 64, and 127 then gives 0 with ram_valid pulsed.
REQ-030 Write 57 to addr 0, 1 to addr 1, then read addr 0 -> ram_output=57 and ram_valid=1 exactly one edge after the read.
REQ-031 Same cycle ram_load=1, ram_read=1, addr 5, data 9 -> ram_valid=0 and ram_output unchanged; a later read of addr 5 gives 9.
REQ-032 Write 0xAAAA to addr 3 while ram_busy=1 -> ignored; read of addr 3 after clear gives 0.
REQ-033 Reset asserted at clear cycle 40 -> after release ram_busy high a full 128 cycles again.
REQ-034 Macro off, DATA_WIDTH=8, ADDR_WIDTH=4 -> ram_busy=0 from reset; write 0xFF to addr 15 then read gives 0xFF.
